// File: rtl/pipeline_pkg.sv
// Shared encodings and the E-stage control bundle for the decode/execute boundary.
package pipeline_pkg;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int ALUCTRL_W = 4;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_write;
    logic                 branch;
    logic                 jump;
    logic                 alu_src;
    logic [1:0]           result_src;
    logic [ALUCTRL_W-1:0] alu_control;
  } e_ctrl_t;

  localparam e_ctrl_t E_CTRL_BUBBLE = '{
    reg_write:   1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    alu_src:     1'b0,
    result_src:  2'b00,
    alu_control: 4'b0000
  };

  // x0 never creates a dependency, so it is excluded before the index compare.
  function automatic logic load_use_hit(input logic [1:0] result_src_e,
                                        input logic [4:0] rd_e,
                                        input logic [4:0] rs1_d,
                                        input logic [4:0] rs2_d);
    return (result_src_e == RESULT_MEM) && (rd_e != 5'd0) &&
           ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// 3:1 select-encoded operand mux feeding the E-stage ALU and store path.
module operand_fwd_mux
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel_i,
  input  logic [DATA_WIDTH-1:0] rf_i,
  input  logic [DATA_WIDTH-1:0] mem_i,
  input  logic [DATA_WIDTH-1:0] wb_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  // Unused encoding 11 falls back to the register-file value.
  always_comb begin
    data_o = rf_i;
    case (sel_i)
      FWD_MEM: data_o = mem_i;
      FWD_WB:  data_o = wb_i;
      default: data_o = rf_i;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use/branch hazard control and operand forwarding.
// Optional hazard performance counters are enabled with HAZARD_PERF_CNT_EN.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] RD1_D,
  input  logic [DATA_WIDTH-1:0] RD2_D,
  input  logic [DATA_WIDTH-1:0] ImmExt_D,
  input  logic [DATA_WIDTH-1:0] PC_D,
  input  logic [DATA_WIDTH-1:0] PCPlus4_D,
  input  logic [4:0]            rs1_D,
  input  logic [4:0]            rs2_D,
  input  logic [4:0]            rd_D,
  input  logic                  RegWrite_D,
  input  logic                  MemWrite_D,
  input  logic                  ALUSrc_D,
  input  logic                  Branch_D,
  input  logic                  Jump_D,
  input  logic [1:0]            ResultSrc_D,
  input  logic [3:0]            ALUControl_D,
  input  logic [1:0]            ForwardA_E,
  input  logic [1:0]            ForwardB_E,
  input  logic [DATA_WIDTH-1:0] ALUResult_M,
  input  logic [DATA_WIDTH-1:0] Result_W,
  input  logic                  PCSrc_E,
  output logic [4:0]            rs1_E,
  output logic [4:0]            rs2_E,
  output logic [4:0]            rd_E,
  output logic                  RegWrite_E,
  output logic                  MemWrite_E,
  output logic                  Branch_E,
  output logic                  Jump_E,
  output logic                  ALUSrc_E,
  output logic [1:0]            ResultSrc_E,
  output logic [3:0]            ALUControl_E,
  output logic [DATA_WIDTH-1:0] PC_E,
  output logic [DATA_WIDTH-1:0] PCPlus4_E,
  output logic [DATA_WIDTH-1:0] ImmExt_E,
  output logic [DATA_WIDTH-1:0] SrcA_E,
  output logic [DATA_WIDTH-1:0] SrcB_E,
  output logic [DATA_WIDTH-1:0] WriteData_E,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE
`ifdef HAZARD_PERF_CNT_EN
 ,output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
`endif
);

  e_ctrl_t               ctrl_q, ctrl_d;
  logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d, pc_q, pc_d, pc4_q, pc4_d;
  logic                  load_use;

  assign load_use = load_use_hit(ctrl_q.result_src, rd_q, rs1_D, rs2_D);
  assign FlushD   = PCSrc_E;
  assign StallF   = load_use && !PCSrc_E;
  assign StallD   = load_use && !PCSrc_E;
  assign FlushE   = load_use || PCSrc_E;

  // A flushed slot becomes an all-zero bubble; otherwise the D fields pass through.
  always_comb begin
    ctrl_d = '{reg_write: RegWrite_D, mem_write: MemWrite_D, branch: Branch_D,
               jump: Jump_D, alu_src: ALUSrc_D, result_src: ResultSrc_D,
               alu_control: ALUControl_D};
    rs1_d  = rs1_D;
    rs2_d  = rs2_D;
    rd_d   = rd_D;
    rd1_d  = RD1_D;
    rd2_d  = RD2_D;
    imm_d  = ImmExt_D;
    pc_d   = PC_D;
    pc4_d  = PCPlus4_D;
    if (FlushE) begin
      ctrl_d = E_CTRL_BUBBLE;
      rs1_d  = 5'd0;
      rs2_d  = 5'd0;
      rd_d   = 5'd0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      pc_d   = '0;
      pc4_d  = '0;
    end else begin
      ctrl_d.reg_write = RegWrite_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= E_CTRL_BUBBLE;
      rs1_q  <= 5'd0;
      rs2_q  <= 5'd0;
      rd_q   <= 5'd0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      pc_q   <= '0;
      pc4_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rs1_q  <= rs1_d;
      rs2_q  <= rs2_d;
      rd_q   <= rd_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      pc_q   <= pc_d;
      pc4_q  <= pc4_d;
    end
  end

  assign rs1_E        = rs1_q;
  assign rs2_E        = rs2_q;
  assign rd_E         = rd_q;
  assign RegWrite_E   = ctrl_q.reg_write;
  assign MemWrite_E   = ctrl_q.mem_write;
  assign Branch_E     = ctrl_q.branch;
  assign Jump_E       = ctrl_q.jump;
  assign ALUSrc_E     = ctrl_q.alu_src;
  assign ResultSrc_E  = ctrl_q.result_src;
  assign ALUControl_E = ctrl_q.alu_control;
  assign PC_E         = pc_q;
  assign PCPlus4_E    = pc4_q;
  assign ImmExt_E     = imm_q;

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_a (
    .sel_i  (ForwardA_E),
    .rf_i   (rd1_q),
    .mem_i  (ALUResult_M),
    .wb_i   (Result_W),
    .data_o (SrcA_E)
  );

  operand_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd_b (
    .sel_i  (ForwardB_E),
    .rf_i   (rd2_q),
    .mem_i  (ALUResult_M),
    .wb_i   (Result_W),
    .data_o (WriteData_E)
  );

  assign SrcB_E = ctrl_q.alu_src ? imm_q : WriteData_E;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Free-running event counters; natural 32-bit overflow provides the wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (FlushE) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected E contents are queued when D is driven.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int EW = 186;
  typedef logic [EW-1:0] ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] RD1_D, RD2_D, ImmExt_D, PC_D, PCPlus4_D, ALUResult_M, Result_W;
  logic [4:0]    rs1_D, rs2_D, rd_D;
  logic          RegWrite_D, MemWrite_D, ALUSrc_D, Branch_D, Jump_D, PCSrc_E;
  logic [1:0]    ResultSrc_D, ForwardA_E, ForwardB_E;
  logic [3:0]    ALUControl_D;
  logic [4:0]    rs1_E, rs2_E, rd_E;
  logic          RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E;
  logic [1:0]    ResultSrc_E;
  logic [3:0]    ALUControl_E;
  logic [DW-1:0] PC_E, PCPlus4_E, ImmExt_E, SrcA_E, SrcB_E, WriteData_E;
  logic          StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   StallCount, FlushCount;
`endif

  int  n_chk = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  id_ex_stage #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RD1_D(RD1_D), .RD2_D(RD2_D), .ImmExt_D(ImmExt_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
    .RegWrite_D(RegWrite_D), .MemWrite_D(MemWrite_D), .ALUSrc_D(ALUSrc_D),
    .Branch_D(Branch_D), .Jump_D(Jump_D), .ResultSrc_D(ResultSrc_D),
    .ALUControl_D(ALUControl_D), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ALUResult_M(ALUResult_M), .Result_W(Result_W), .PCSrc_E(PCSrc_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .Branch_E(Branch_E),
    .Jump_E(Jump_E), .ALUSrc_E(ALUSrc_E), .ResultSrc_E(ResultSrc_E),
    .ALUControl_E(ALUControl_E), .PC_E(PC_E), .PCPlus4_E(PCPlus4_E), .ImmExt_E(ImmExt_E),
    .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .WriteData_E(WriteData_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
`ifdef HAZARD_PERF_CNT_EN
   ,.StallCount(StallCount), .FlushCount(FlushCount)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Expected E contents if the current D inputs are loaded (RD1/RD2 seen through FWD_RF).
  function automatic ev_t d_pack();
    return {rd_D, rs1_D, rs2_D, RegWrite_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D,
            ResultSrc_D, ALUControl_D, PC_D, PCPlus4_D, ImmExt_D, RD1_D, RD2_D};
  endfunction

  function automatic ev_t e_obs();
    return {rd_E, rs1_E, rs2_E, RegWrite_E, MemWrite_E, Branch_E, Jump_E, ALUSrc_E,
            ResultSrc_E, ALUControl_E, PC_E, PCPlus4_E, ImmExt_E, SrcA_E, WriteData_E};
  endfunction

  function automatic logic [DW-1:0] fwd_model(input logic [1:0] sel, input logic [DW-1:0] rf);
    if (sel == 2'b10) return ALUResult_M;
    else if (sel == 2'b01) return Result_W;
    else return rf;
  endfunction

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] rsrc);
    rs1_D = rs1; rs2_D = rs2; rd_D = rd; ResultSrc_D = rsrc;
    RD1_D = $urandom; RD2_D = $urandom; ImmExt_D = $urandom;
    PC_D = $urandom; PCPlus4_D = PC_D + 32'd4;
    RegWrite_D = 1'($urandom); MemWrite_D = 1'($urandom); ALUSrc_D = 1'($urandom);
    Branch_D = 1'($urandom); Jump_D = 1'($urandom); ALUControl_D = 4'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ev_t o;
    rst_n = 1'b0; PCSrc_E = 1'b0; ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    ALUResult_M = $urandom; Result_W = $urandom;
    for (int i = 0; i < 3; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom));
      step();
    end
    o = e_obs();
    n_chk++;
    if (o !== '0) begin
      n_fail++; $display("FAIL reset_e: got %h expected 0", o);
    end
    n_chk++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_hazard: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    end
    set_d(5'd1, 5'd2, 5'd3, RESULT_ALU);
    rst_n = 1'b1;
    exp_q.push_back(d_pack());
    step();
    o = e_obs();
    n_chk++;
    if (o !== exp_q[0]) begin
      n_fail++; $display("FAIL first_load: got %h expected %h", o, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_passthrough();
    ev_t o, e;
    for (int i = 0; i < 4; i++) begin
      set_d(5'($urandom), 5'($urandom), 5'($urandom), (i % 2 == 0) ? RESULT_ALU : RESULT_PC4);
      exp_q.push_back(d_pack());
      step();
      o = e_obs(); e = exp_q.pop_front();
      n_chk++;
      if (o !== e) begin
        n_fail++; $display("FAIL pass[%0d]: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_load_use();
    ev_t o, e;
    set_d(5'd1, 5'd2, 5'd5, RESULT_MEM);
    exp_q.push_back(d_pack());
    step();
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL lu_load: got %h expected %h", o, e);
    end
    set_d(5'd5, 5'd9, 5'd6, RESULT_ALU);
    #1;
    n_chk++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
      n_fail++; $display("FAIL lu_hazard: got %b expected 1101", {StallF, StallD, FlushD, FlushE});
    end
    exp_q.push_back('0);
    step();
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL lu_bubble: got %h expected %h", o, e);
    end
    n_chk++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_fail++; $display("FAIL lu_release: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    end
    exp_q.push_back(d_pack());
    step();
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL lu_dependent: got %h expected %h", o, e);
    end
  endtask

  task automatic test_load_use_branch();
    ev_t o, e;
    set_d(5'd1, 5'd2, 5'd5, RESULT_MEM);
    step();
    set_d(5'd3, 5'd5, 5'd6, RESULT_ALU);
    PCSrc_E = 1'b1;
    #1;
    n_chk++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
      n_fail++; $display("FAIL lu_branch_hazard: got %b expected 0011", {StallF, StallD, FlushD, FlushE});
    end
    exp_q.push_back('0);
    step();
    PCSrc_E = 1'b0;
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL lu_branch_bubble: got %h expected %h", o, e);
    end
  endtask

  task automatic test_x0();
    ev_t o, e;
    set_d(5'd1, 5'd2, 5'd0, RESULT_MEM);
    step();
    set_d(5'd0, 5'd0, 5'd7, RESULT_ALU);
    #1;
    n_chk++;
    if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_fail++; $display("FAIL x0_hazard: got %b expected 0000", {StallF, StallD, FlushD, FlushE});
    end
    exp_q.push_back(d_pack());
    step();
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL x0_load: got %h expected %h", o, e);
    end
  endtask

  task automatic test_forward();
    logic [DW-1:0] ea, eb, es;
    for (int pass = 0; pass < 2; pass++) begin
      set_d(5'd1, 5'd2, 5'd3, RESULT_ALU);
      RD1_D = 32'h11; RD2_D = 32'h44; ImmExt_D = 32'h55;
      ALUSrc_D = (pass == 0) ? 1'b1 : 1'b0;
      step();
      ALUResult_M = 32'h22; Result_W = 32'h33;
      for (int s = 0; s < 4; s++) begin
        ForwardA_E = 2'(s); ForwardB_E = 2'(3 - s);
        #1;
        ea = fwd_model(2'(s), 32'h11);
        eb = fwd_model(2'(3 - s), 32'h44);
        es = (pass == 0) ? 32'h55 : eb;
        n_chk++;
        if (SrcA_E !== ea) begin
          n_fail++; $display("FAIL fwd_a[%0d]: got %h expected %h", s, SrcA_E, ea);
        end
        n_chk++;
        if (WriteData_E !== eb) begin
          n_fail++; $display("FAIL fwd_wd[%0d]: got %h expected %h", s, WriteData_E, eb);
        end
        n_chk++;
        if (SrcB_E !== es) begin
          n_fail++; $display("FAIL fwd_srcb[%0d]: got %h expected %h", s, SrcB_E, es);
        end
      end
      ForwardA_E = 2'b00; ForwardB_E = 2'b00;
    end
  endtask

  task automatic test_reset_mid_stall();
    ev_t o, e;
    set_d(5'd1, 5'd2, 5'd8, RESULT_MEM);
    step();
    set_d(5'd4, 5'd8, 5'd9, RESULT_ALU);
    #1;
    n_chk++;
    if (StallD !== 1'b1) begin
      n_fail++; $display("FAIL mid_stall_pre: got %b expected 1", StallD);
    end
    rst_n = 1'b0;
    #1;
    o = e_obs();
    n_chk++;
    if (o !== '0 || {StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
      n_fail++; $display("FAIL mid_stall_reset: got %h/%b expected 0/0000", o, {StallF, StallD, FlushD, FlushE});
    end
    step();
    rst_n = 1'b1;
    exp_q.push_back(d_pack());
    step();
    o = e_obs(); e = exp_q.pop_front();
    n_chk++;
    if (o !== e) begin
      n_fail++; $display("FAIL mid_stall_after: got %h expected %h", o, e);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counters();
    rst_n = 1'b0; PCSrc_E = 1'b0;
    set_d(5'd0, 5'd0, 5'd0, RESULT_ALU);
    step();
    n_chk++;
    if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
      n_fail++; $display("FAIL cnt_reset: got %0d/%0d expected 0/0", StallCount, FlushCount);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_d(5'd1, 5'd2, 5'd7, RESULT_MEM); step();
      set_d(5'd7, 5'd3, 5'd4, RESULT_ALU); step();
      set_d(5'd0, 5'd0, 5'd4, RESULT_ALU); step();
    end
    for (int i = 0; i < 2; i++) begin
      PCSrc_E = 1'b1; step();
      PCSrc_E = 1'b0; step();
    end
    n_chk++;
    if (StallCount !== 32'd3 || FlushCount !== 32'd5) begin
      n_fail++; $display("FAIL cnt_events: got %0d/%0d expected 3/5", StallCount, FlushCount);
    end
    dut.stall_cnt_q = 32'hFFFF_FFFF;
    set_d(5'd1, 5'd2, 5'd7, RESULT_MEM); step();
    set_d(5'd7, 5'd3, 5'd4, RESULT_ALU); step();
    n_chk++;
    if (StallCount !== 32'd0) begin
      n_fail++; $display("FAIL cnt_wrap: got %h expected 0", StallCount);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_load_use_branch();
    test_x0();
    test_forward();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
